i281_data_memory_bank: RTL
==========================

# i281_data_memory_bank

Sixteen-entry, 8-bit data memory for the i281 CPU. It holds the byte array whose sixteen words drive the inputs of the 8-wide 16-to-1 read bus mux directly. The mux's Select is the read address and its result is the read data, so reads are combinational through the mux and no read port is implemented here. The block provides:
- a synchronous CPU write port;
- a post-reset preload sequencer that loads an image one byte per clock;
- a memory-mapped input byte that the PONG controller updates through a strobe.

## Interface
- INIT_IMAGE, 128'h0: preload image; word i = INIT_IMAGE[8i+7:8i].
- IO_ADDR, 4'd15: word address updated by io_strobe.

- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset.
- write_en  in  1  CPU store request.
- write_addr  in  4  store word address.
- write_data  in  8  store data.
- io_strobe  in  1  external input byte valid.
- io_in  in  8  external input byte.
- clear_req  in  1  restart preload sweep.
- mem_flat  out  128  all sixteen words; word i on [8i+7:8i], feeds mux inputs 0..15.
- busy  out  1  preload sweep in progress.
- write_ack  out  1  one-cycle pulse: CPU store committed.
- write_drop  out  1  one-cycle pulse: CPU store discarded.
- io_overrun  out  1  one-cycle pulse: io byte lost to a same-cycle CPU store.

## Operation
- Clock is the single clock. Reset is synchronous and active-low.
- The block has two states, INIT and RUN, and a 4-bit sweep counter cnt.
- Reset low at an edge:
  - all words 0x00;
  - state INIT, cnt 0;
  - busy 1;
  - write_ack, write_drop and io_overrun 0.
- INIT, clear_req low: word[cnt] <= INIT_IMAGE word cnt, and cnt increments.
  - When cnt = 15 is written, state goes to RUN and cnt wraps to 0.
- INIT, clear_req high: cnt <= 0, and no word is written that edge.
- INIT, write_en high: the store is discarded and write_drop pulses. io_strobe is ignored silently.
- RUN, write_en high: word[write_addr] <= write_data and write_ack pulses.
- RUN, io_strobe high: word[IO_ADDR] <= io_in.
- RUN, write_en and io_strobe both high:
  - write_addr = IO_ADDR: the CPU store wins, write_ack pulses and io_overrun pulses.
  - otherwise: both writes commit.
- RUN, clear_req high:
  - state goes to INIT with cnt 0, and the sweep starts on the following edge;
  - any same-cycle write_en or io_strobe is discarded, and write_drop pulses if write_en was high.
- busy is registered and equals (state == INIT).
- mem_flat is a direct register output with no combinational path from any input.

## Timing
- Write latency: data appears on mem_flat one edge after write_en is sampled. The read is then combinational through the downstream mux in the same cycle.
- Preload after reset release: 16 edges. Word i updates at edge i+1. busy falls at edge 16, together with the word 15 write.
- clear_req from RUN: busy rises at the next edge, and the total sweep is 17 edges.
- Pulse outputs are high for exactly one cycle per triggering edge and are never held.
- Reset asserted mid-sweep or mid-write overrides everything at that edge.
- There is no back-pressure. The CPU must poll busy or tolerate write_drop.

## Test plan
- Reset low 2 cycles, INIT_IMAGE = {8'h0F..8'h00} (word i = i) -> mem_flat all zero and busy = 1 during reset. After release, word i = i at edge i+1, and busy = 0 after edge 16.
- In RUN, write_en with addr 4'h3 and data 8'hA5 -> word3 = A5 next cycle, write_ack single pulse, other words unchanged.
- In RUN, io_strobe with io_in 8'h7E, plus write_en with addr 4'hF and data 8'h11, same cycle -> word15 = 11, write_ack and io_overrun each pulse once. Repeated with addr 4'h2 -> word2 = 11, word15 = 7E, no overrun.
- write_en during cycle 5 of the sweep -> write_drop pulses and the target word ends at its INIT_IMAGE value.
- clear_req mid-sweep at cnt = 9 -> cnt restarts at 0 and busy stays high 16 more edges. clear_req in RUN after a write of 8'hFF to word0 -> word0 returns to its image value after the sweep.
- Reset asserted at cnt = 7 -> all words 0x00 at that edge and a full 16-edge sweep after release.

Source files
------------

// File: rtl/i281_data_memory_bank.sv
// Sixteen-word, 8-bit data memory for the i281 CPU with a post-reset preload sweep,
// a CPU store port and a strobed memory-mapped input byte. Reads happen downstream.
module i281_data_memory_bank #(
  parameter logic [127:0] INIT_IMAGE = 128'h0,
  parameter logic [3:0]   IO_ADDR    = 4'd15
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         write_en,
  input  logic [3:0]   write_addr,
  input  logic [7:0]   write_data,
  input  logic         io_strobe,
  input  logic [7:0]   io_in,
  input  logic         clear_req,
  output logic [127:0] mem_flat,
  output logic         busy,
  output logic         write_ack,
  output logic         write_drop,
  output logic         io_overrun
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [15:0][7:0] IMAGE = INIT_IMAGE;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [15:0][7:0] r_mem;
  logic             r_busy;
  logic             r_ack;
  logic             r_drop;
  logic             r_ovr;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_pre_we;
  logic       w_cpu_we;
  logic       w_io_we;
  logic       w_ack_nxt;
  logic       w_drop_nxt;
  logic       w_ovr_nxt;
  logic       w_io_hit;

  assign w_io_hit = write_en && (write_addr == IO_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pre_we    = 1'b0;
    w_cpu_we    = 1'b0;
    w_io_we     = 1'b0;
    w_ack_nxt   = 1'b0;
    w_drop_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;
    case (r_state)
      S_INIT: begin
        // Stores are refused while the image is loading; io bytes vanish quietly.
        w_drop_nxt = write_en;
        if (clear_req) begin
          w_cnt_nxt = 4'd0;
        end else begin
          w_pre_we  = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd15) w_state_nxt = S_RUN;
        end
      end
      default: begin
        if (clear_req) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = 4'd0;
          w_drop_nxt  = write_en;
        end else begin
          // A CPU store to the io word beats the io byte in the same cycle.
          w_cpu_we  = write_en;
          w_ack_nxt = write_en;
          w_io_we   = io_strobe && !w_io_hit;
          w_ovr_nxt = io_strobe && w_io_hit;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_INIT;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
      r_drop  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_INIT);
      r_ack   <= w_ack_nxt;
      r_drop  <= w_drop_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_mem <= '0;
    end else begin
      if (w_pre_we) r_mem[r_cnt]      <= IMAGE[r_cnt];
      if (w_io_we)  r_mem[IO_ADDR]    <= io_in;
      if (w_cpu_we) r_mem[write_addr] <= write_data;
    end
  end

  assign mem_flat   = r_mem;
  assign busy       = r_busy;
  assign write_ack  = r_ack;
  assign write_drop = r_drop;
  assign io_overrun = r_ovr;

endmodule
